// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//   Raster timing generator for the 2048 board renderer. Default parameters
//   give SVGA 800x600@72Hz from a 50 MHz clock.
//
//   Ports
//     CLK          system clock
//     RST          asynchronous reset, active low
//     row          current line   (vertical counter, zero-extended)
//     col          current pixel  (horizontal counter, zero-extended)
//     vnotactive   high while row >= V_VIS (vertical blank)
//     hsync        horizontal sync, PIPE_DELAY ticks behind row/col
//     vsync        vertical sync,   PIPE_DELAY ticks behind row/col
//     de           display enable,  PIPE_DELAY ticks behind row/col
//     pix_tick     one-CLK pulse; the counters advance on the next edge
//     frame_start  one-CLK pulse on the cycle row/col wrap to (0,0)
// ---------------------------------------------------------------------------
module vga_timing #(
  parameter int unsigned H_VIS      = 800,
  parameter int unsigned H_FP       = 56,
  parameter int unsigned H_SYNC     = 120,
  parameter int unsigned H_BP       = 64,
  parameter int unsigned V_VIS      = 600,
  parameter int unsigned V_FP       = 37,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 23,
  parameter logic        SYNC_POL   = 1'b1,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        vnotactive,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pix_tick,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Phase boundaries, sized to the counters so every compare is same-width
  localparam logic [10:0] HC_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] HC_FP_BEG   = 11'(H_VIS);
  localparam logic [10:0] HC_SYNC_BEG = 11'(H_VIS + H_FP);
  localparam logic [10:0] HC_BP_BEG   = 11'(H_VIS + H_FP + H_SYNC);

  localparam logic [9:0]  VC_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VC_FP_BEG   = 10'(V_VIS);
  localparam logic [9:0]  VC_SYNC_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VC_BP_BEG   = 10'(V_VIS + V_FP + V_SYNC);

  localparam logic [3:0]  DIV_LAST    = 4'(CLK_DIV - 1);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (H_TOTAL >= 2048) begin : g_bad_htotal
    $error("vga_timing: H_TOTAL must be below 2048");
  end
  if (V_TOTAL >= 1024) begin : g_bad_vtotal
    $error("vga_timing: V_TOTAL must be below 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing: CLK_DIV must be in 1..16");
  end
  if (PIPE_DELAY > 4) begin : g_bad_pipe
    $error("vga_timing: PIPE_DELAY must be in 0..4");
  end

  typedef enum logic [1:0] {
    PH_VIS,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

  logic [3:0]  r_divcnt;
  logic        r_pix_tick;
  logic [10:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_hs_raw;
  logic        r_vs_raw;
  logic        r_de_raw;
  logic        r_vnotactive;
  logic        r_frame_start;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [10:0] w_hcnt_nxt;
  logic [9:0]  w_vcnt_nxt;
  phase_t      w_hph_nxt;
  phase_t      w_vph_nxt;

  // -------------------------------------------------------------------------
  // Pixel clock divider. pix_tick is registered, so the counters move on the
  // edge after it is seen high; out of reset the first advance is therefore
  // one tick after release.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_divcnt   <= '0;
      r_pix_tick <= 1'b0;
    end else if (r_divcnt == DIV_LAST) begin
      r_divcnt   <= '0;
      r_pix_tick <= 1'b1;
    end else begin
      r_divcnt   <= r_divcnt + 4'd1;
      r_pix_tick <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Next counter values
  // -------------------------------------------------------------------------
  always_comb begin
    w_h_wrap   = (r_hcnt == HC_LAST);
    w_v_wrap   = (r_vcnt == VC_LAST);
    w_hcnt_nxt = w_h_wrap ? '0 : r_hcnt + 11'd1;
    w_vcnt_nxt = r_vcnt;
    if (w_h_wrap) begin
      w_vcnt_nxt = w_v_wrap ? '0 : r_vcnt + 10'd1;
    end
  end

  // Phase decode of the next position; the raw strobes are registered from
  // it so they line up with row/col on the same cycle.
  always_comb begin
    w_hph_nxt = PH_BP;
    if (w_hcnt_nxt < HC_FP_BEG) begin
      w_hph_nxt = PH_VIS;
    end else if (w_hcnt_nxt < HC_SYNC_BEG) begin
      w_hph_nxt = PH_FP;
    end else if (w_hcnt_nxt < HC_BP_BEG) begin
      w_hph_nxt = PH_SYNC;
    end
  end

  always_comb begin
    w_vph_nxt = PH_BP;
    if (w_vcnt_nxt < VC_FP_BEG) begin
      w_vph_nxt = PH_VIS;
    end else if (w_vcnt_nxt < VC_SYNC_BEG) begin
      w_vph_nxt = PH_FP;
    end else if (w_vcnt_nxt < VC_BP_BEG) begin
      w_vph_nxt = PH_SYNC;
    end
  end

  // -------------------------------------------------------------------------
  // Counters and raw timing strobes
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hs_raw      <= ~SYNC_POL;
      r_vs_raw      <= ~SYNC_POL;
      r_de_raw      <= 1'b0;
      r_vnotactive  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= r_pix_tick && w_h_wrap && w_v_wrap;
      if (r_pix_tick) begin
        r_hcnt       <= w_hcnt_nxt;
        r_vcnt       <= w_vcnt_nxt;
        r_hs_raw     <= (w_hph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        r_vs_raw     <= (w_vph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        r_de_raw     <= (w_hph_nxt == PH_VIS) && (w_vph_nxt == PH_VIS);
        r_vnotactive <= (w_vcnt_nxt >= VC_FP_BEG);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output delay line, advancing on pixel ticks only
  // -------------------------------------------------------------------------
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign hsync = r_hs_raw;
    assign vsync = r_vs_raw;
    assign de    = r_de_raw;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] r_hs_pipe;
    logic [PIPE_DELAY-1:0] r_vs_pipe;
    logic [PIPE_DELAY-1:0] r_de_pipe;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_hs_pipe <= {PIPE_DELAY{~SYNC_POL}};
        r_vs_pipe <= {PIPE_DELAY{~SYNC_POL}};
        r_de_pipe <= '0;
      end else if (r_pix_tick) begin
        r_hs_pipe[0] <= r_hs_raw;
        r_vs_pipe[0] <= r_vs_raw;
        r_de_pipe[0] <= r_de_raw;
        for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
          r_hs_pipe[i] <= r_hs_pipe[i-1];
          r_vs_pipe[i] <= r_vs_pipe[i-1];
          r_de_pipe[i] <= r_de_pipe[i-1];
        end
      end
    end

    assign hsync = r_hs_pipe[PIPE_DELAY-1];
    assign vsync = r_vs_pipe[PIPE_DELAY-1];
    assign de    = r_de_pipe[PIPE_DELAY-1];
  end

  assign row         = 32'(r_vcnt);
  assign col         = 32'(r_hcnt);
  assign vnotactive  = r_vnotactive;
  assign pix_tick    = r_pix_tick;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//   Four instances on one clock/reset:
//     A: small raster 15x8 (vis 8/fp 2/sync 3/bp 2, vis 4/fp 1/sync 2/bp 1),
//        CLK_DIV=1, PIPE_DELAY=1, SYNC_POL=1
//     B: same raster, CLK_DIV=2
//     C: same raster, PIPE_DELAY=0, SYNC_POL=0
//     D: default SVGA parameters (first line only)
//   Cycle k counts rising edges after reset release; with CLK_DIV=1 the
//   position reached after edge k is p = k-1.
// ---------------------------------------------------------------------------
module tb_vga_timing;

  logic CLK;
  logic RST;

  logic [31:0] row_a, col_a, row_b, col_b, row_c, col_c, row_d, col_d;
  logic vna_a, hs_a, vs_a, de_a, pt_a, fs_a;
  logic vna_b, hs_b, vs_b, de_b, pt_b, fs_b;
  logic vna_c, hs_c, vs_c, de_c, pt_c, fs_c;
  logic vna_d, hs_d, vs_d, de_d, pt_d, fs_d;

  vga_timing #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CLK_DIV(1), .PIPE_DELAY(1)
  ) u_a (
    .CLK(CLK), .RST(RST), .row(row_a), .col(col_a), .vnotactive(vna_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .pix_tick(pt_a), .frame_start(fs_a)
  );

  vga_timing #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CLK_DIV(2), .PIPE_DELAY(1)
  ) u_b (
    .CLK(CLK), .RST(RST), .row(row_b), .col(col_b), .vnotactive(vna_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .pix_tick(pt_b), .frame_start(fs_b)
  );

  vga_timing #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .CLK_DIV(1), .PIPE_DELAY(0)
  ) u_c (
    .CLK(CLK), .RST(RST), .row(row_c), .col(col_c), .vnotactive(vna_c),
    .hsync(hs_c), .vsync(vs_c), .de(de_c), .pix_tick(pt_c), .frame_start(fs_c)
  );

  vga_timing u_d (
    .CLK(CLK), .RST(RST), .row(row_d), .col(col_d), .vnotactive(vna_d),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .pix_tick(pt_d), .frame_start(fs_d)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned checks;
  int unsigned failures;
  int unsigned cyc;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // One rising edge, then sample on the falling edge
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk32({tag, "_a_row"}, row_a, 0);
    chk32({tag, "_a_col"}, col_a, 0);
    chk1({tag, "_a_vna"}, vna_a, 1'b0);
    chk1({tag, "_a_hs"}, hs_a, 1'b0);
    chk1({tag, "_a_vs"}, vs_a, 1'b0);
    chk1({tag, "_a_de"}, de_a, 1'b0);
    chk1({tag, "_a_pt"}, pt_a, 1'b0);
    chk1({tag, "_a_fs"}, fs_a, 1'b0);
    chk32({tag, "_b_rowcol"}, row_b | col_b, 0);
    chk1({tag, "_b_flags"}, vna_b | hs_b | vs_b | de_b | pt_b | fs_b, 1'b0);
    chk32({tag, "_c_rowcol"}, row_c | col_c, 0);
    chk1({tag, "_c_hs"}, hs_c, 1'b1);
    chk1({tag, "_c_vs"}, vs_c, 1'b1);
    chk1({tag, "_c_flags"}, vna_c | de_c | pt_c | fs_c, 1'b0);
    chk32({tag, "_d_rowcol"}, row_d | col_d, 0);
    chk1({tag, "_d_flags"}, vna_d | hs_d | vs_d | de_d | pt_d | fs_d, 1'b0);
  endtask

  // fa = {vna, hs, vs, de, pix_tick, frame_start} of A
  // fc = {hs, vs, de} of C
  typedef struct {
    logic [31:0] k;
    logic [31:0] row;
    logic [31:0] col;
    logic [5:0]  fa;
    logic [31:0] colb;
    logic        ptb;
    logic [2:0]  fc;
  } vec_t;

  localparam int unsigned NV = 20;
  vec_t vecs [NV];

  int unsigned first_fs;
  int unsigned n;

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;

    vecs[0]  = '{1,   0, 0,  6'b000010, 0,  1'b0, 3'b110};
    vecs[1]  = '{2,   0, 1,  6'b000010, 0,  1'b1, 3'b111};
    vecs[2]  = '{3,   0, 2,  6'b000110, 1,  1'b0, 3'b111};
    vecs[3]  = '{9,   0, 8,  6'b000110, 4,  1'b0, 3'b110};
    vecs[4]  = '{10,  0, 9,  6'b000010, 4,  1'b1, 3'b110};
    vecs[5]  = '{11,  0, 10, 6'b000010, 5,  1'b0, 3'b010};
    vecs[6]  = '{12,  0, 11, 6'b010010, 5,  1'b1, 3'b010};
    vecs[7]  = '{13,  0, 12, 6'b010010, 6,  1'b0, 3'b010};
    vecs[8]  = '{14,  0, 13, 6'b010010, 6,  1'b1, 3'b110};
    vecs[9]  = '{15,  0, 14, 6'b000010, 7,  1'b0, 3'b110};
    vecs[10] = '{16,  1, 0,  6'b000010, 7,  1'b1, 3'b111};
    vecs[11] = '{17,  1, 1,  6'b000110, 8,  1'b0, 3'b111};
    vecs[12] = '{61,  4, 0,  6'b100010, 0,  1'b0, 3'b110};
    vecs[13] = '{76,  5, 0,  6'b100010, 7,  1'b1, 3'b100};
    vecs[14] = '{77,  5, 1,  6'b101010, 8,  1'b0, 3'b100};
    vecs[15] = '{106, 7, 0,  6'b101010, 7,  1'b1, 3'b110};
    vecs[16] = '{107, 7, 1,  6'b100010, 8,  1'b0, 3'b110};
    vecs[17] = '{120, 7, 14, 6'b100010, 14, 1'b1, 3'b110};
    vecs[18] = '{121, 0, 0,  6'b000011, 0,  1'b0, 3'b111};
    vecs[19] = '{122, 0, 1,  6'b000110, 0,  1'b1, 3'b111};

    // Reset held across several edges
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_state("rst");

    RST = 1'b1;
    cyc = 0;

    for (int unsigned i = 0; i < NV; i++) begin
      while (cyc < vecs[i].k) step();
      chk32("a_row", row_a, vecs[i].row);
      chk32("a_col", col_a, vecs[i].col);
      chk32("c_row", row_c, vecs[i].row);
      chk32("c_col", col_c, vecs[i].col);
      chk1("a_vna", vna_a, vecs[i].fa[5]);
      chk1("a_hs", hs_a, vecs[i].fa[4]);
      chk1("a_vs", vs_a, vecs[i].fa[3]);
      chk1("a_de", de_a, vecs[i].fa[2]);
      chk1("a_pt", pt_a, vecs[i].fa[1]);
      chk1("a_fs", fs_a, vecs[i].fa[0]);
      chk32("b_col", col_b, vecs[i].colb);
      chk1("b_pt", pt_b, vecs[i].ptb);
      chk1("c_hs", hs_c, vecs[i].fc[2]);
      chk1("c_vs", vs_c, vecs[i].fc[1]);
      chk1("c_de", de_c, vecs[i].fc[0]);
    end

    // Frame period: next A pulse 120 CLK after the one at k=121; B's first
    // pulse (240 CLK per frame) lands on the same edge.
    n = 0;
    while (!fs_a && n < 300) begin
      step();
      n++;
    end
    chk32("a_frame_period_k", cyc, 241);
    chk1("b_fs_first", fs_b, 1'b1);
    chk32("b_row_at_wrap", row_b, 0);
    step();
    chk1("a_fs_one_clk", fs_a, 1'b0);
    chk1("b_fs_one_clk", fs_b, 1'b0);
    chk32("b_col_hold", col_b, 0);

    // Mid-frame asynchronous reset, asserted between clock edges
    while (cyc < 290) step();
    chk32("a_row_pre_abort", row_a, 3);
    chk32("a_col_pre_abort", col_a, 4);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1 chk_reset_state("abort");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    cyc = 0;

    // Restart from (0,0): no pulse for the aborted frame, first pulse after
    // one full frame; default-parameter instance checked on its first line.
    first_fs = 0;
    for (int unsigned k = 1; k <= 1041; k++) begin
      step();
      if (fs_a && first_fs == 0) first_fs = cyc;
      if (cyc == 800) begin
        chk32("d_col_799", col_d, 799);
        chk32("d_row_0", row_d, 0);
      end
      if (cyc == 801) chk1("d_de_last", de_d, 1'b1);
      if (cyc == 802) chk1("d_de_off", de_d, 1'b0);
      if (cyc == 857) chk1("d_hs_pre", hs_d, 1'b0);
      if (cyc == 858) chk1("d_hs_rise", hs_d, 1'b1);
      if (cyc == 977) chk1("d_hs_last", hs_d, 1'b1);
      if (cyc == 978) chk1("d_hs_fall", hs_d, 1'b0);
      if (cyc == 1041) begin
        chk32("d_row_wrap", row_d, 1);
        chk32("d_col_wrap", col_d, 0);
      end
    end
    chk32("a_fs_after_abort_k", first_fs, 121);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
